// File: rtl/wb_tgt_ram.sv
// wb_tgt_ram: pipelined Wishbone target backed by a small synchronous RAM.
// Fixed-latency response pipeline; STALL is driven from an outstanding-request credit counter.
// Optional build macro WB_TGT_RAM_STALL_INJECT_EN adds LFSR-driven random stall injection.
module wb_tgt_ram #(
    parameter int unsigned ADR_WIDTH       = 16,
    parameter int unsigned DAT_WIDTH       = 16,
    parameter int unsigned SEL_WIDTH       = 2,
    parameter int unsigned TGD_WIDTH       = 1,
    parameter int unsigned MEM_AW          = 4,
    parameter int unsigned LATENCY         = 2,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                 clk_i,
    input  logic                 async_rst_i,
    input  logic                 sync_rst_i,
    input  logic                 tgt_cyc_i,
    input  logic                 tgt_stb_i,
    input  logic                 tgt_we_i,
    input  logic                 tgt_lock_i,
    input  logic [SEL_WIDTH-1:0] tgt_sel_i,
    input  logic [ADR_WIDTH-1:0] tgt_adr_i,
    input  logic [DAT_WIDTH-1:0] tgt_dat_i,
    input  logic [TGD_WIDTH-1:0] tgt_tgd_i,
    output logic                 tgt_ack_o,
    output logic                 tgt_err_o,
    output logic                 tgt_rty_o,
    output logic                 tgt_stall_o,
    output logic [DAT_WIDTH-1:0] tgt_dat_o,
    output logic [TGD_WIDTH-1:0] tgt_tgd_o
);

    localparam int unsigned LANE_W = DAT_WIDTH / SEL_WIDTH;
    localparam int unsigned DEPTH  = 2 ** MEM_AW;
    localparam int unsigned CNT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    typedef struct packed {
        logic                 valid;
        logic                 is_err;
        logic [DAT_WIDTH-1:0] dat;
        logic [TGD_WIDTH-1:0] tgd;
    } rsp_t;

    rsp_t                 pipe_q [LATENCY];
    rsp_t                 pipe_d [LATENCY];
    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     cnt_d;
    logic [DAT_WIDTH-1:0] mem_q  [DEPTH];
    logic [TGD_WIDTH-1:0] tag_q  [DEPTH];

    logic              in_range;
    logic [MEM_AW-1:0] mem_idx;
    logic              last_valid;
    logic              cnt_stall;
    logic              stall;
    logic              accept;
    logic              wr_en;
    logic              unused_ok;

    assign unused_ok  = tgt_lock_i;
    assign mem_idx    = tgt_adr_i[MEM_AW-1:0];
    assign in_range   = (tgt_adr_i >> MEM_AW) == '0;
    assign last_valid = pipe_q[LATENCY-1].valid;
    assign cnt_stall  = (cnt_q == CNT_MAX) & ~last_valid;

`ifdef WB_TGT_RAM_STALL_INJECT_EN
    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    // Fibonacci LFSR (taps 8,6,5,4) that randomly injects extra stall cycles.
    always_comb begin
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        if (sync_rst_i) begin
            lfsr_d = 8'hA5;
        end
    end

    // LFSR state register.
    always_ff @(posedge clk_i or posedge async_rst_i) begin
        if (async_rst_i) begin
            lfsr_q <= 8'hA5;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign stall = cnt_stall | (lfsr_q[1:0] == 2'b00);
`else
    assign stall = cnt_stall;
`endif

    assign accept = tgt_cyc_i & tgt_stb_i & ~stall & ~sync_rst_i;
    assign wr_en  = accept & tgt_we_i & in_range;

    // Response pipeline shift, outstanding-credit update, abort and synchronous reset.
    always_comb begin
        pipe_d[0]        = '0;
        pipe_d[0].valid  = accept;
        pipe_d[0].is_err = ~in_range;
        if (in_range && !tgt_we_i) begin
            pipe_d[0].dat = mem_q[mem_idx];
            pipe_d[0].tgd = tag_q[mem_idx];
        end
        for (int unsigned k = 1; k < LATENCY; k++) begin
            pipe_d[k] = pipe_q[k-1];
        end

        cnt_d = cnt_q;
        if (accept && !last_valid && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!accept && last_valid && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end

        // A dropped cycle discards every pending response; sync reset clears everything.
        if (!tgt_cyc_i || sync_rst_i) begin
            cnt_d = '0;
            for (int unsigned k = 0; k < LATENCY; k++) begin
                pipe_d[k].valid = 1'b0;
            end
        end
        if (sync_rst_i) begin
            for (int unsigned k = 0; k < LATENCY; k++) begin
                pipe_d[k] = '0;
            end
        end
    end

    // Pipeline and credit counter registers.
    always_ff @(posedge clk_i or posedge async_rst_i) begin
        if (async_rst_i) begin
            for (int unsigned k = 0; k < LATENCY; k++) begin
                pipe_q[k] <= '0;
            end
            cnt_q <= '0;
        end else begin
            pipe_q <= pipe_d;
            cnt_q  <= cnt_d;
        end
    end

    // RAM and tag array; contents survive reset.
    always_ff @(posedge clk_i) begin
        for (int unsigned k = 0; k < SEL_WIDTH; k++) begin
            if (wr_en && tgt_sel_i[k]) begin
                mem_q[mem_idx][k*LANE_W +: LANE_W] <= tgt_dat_i[k*LANE_W +: LANE_W];
            end
        end
        if (wr_en && (|tgt_sel_i)) begin
            tag_q[mem_idx] <= tgt_tgd_i;
        end
    end

    assign tgt_ack_o   = last_valid & ~pipe_q[LATENCY-1].is_err;
    assign tgt_err_o   = last_valid &  pipe_q[LATENCY-1].is_err;
    assign tgt_rty_o   = 1'b0;
    assign tgt_stall_o = stall;
    assign tgt_dat_o   = last_valid ? pipe_q[LATENCY-1].dat : '0;
    assign tgt_tgd_o   = last_valid ? pipe_q[LATENCY-1].tgd : '0;

endmodule

// File: tb/tb_wb_tgt_ram.sv
// tb_wb_tgt_ram: randomized and directed bench for wb_tgt_ram with a queue-based response model.
// dut_a uses the default configuration, dut_b uses LATENCY=3, MAX_OUTSTANDING=1.
module tb_wb_tgt_ram;

    logic        clk = 1'b0;
    logic        async_rst_i;
    logic        sync_rst_i;
    logic        cyc1, stb1, cyc2, stb2;
    logic        we, lock;
    logic [1:0]  sel;
    logic [15:0] adr, wdat;
    logic [0:0]  tgd;
    logic        ack1, err1, rty1, stall1;
    logic [15:0] dato1;
    logic [0:0]  tgdo1;
    logic        ack2, err2, rty2, stall2;
    logic [15:0] dato2;
    logic [0:0]  tgdo2;

    always #5 clk = ~clk;

    wb_tgt_ram dut_a (
        .clk_i(clk), .async_rst_i(async_rst_i), .sync_rst_i(sync_rst_i),
        .tgt_cyc_i(cyc1), .tgt_stb_i(stb1), .tgt_we_i(we), .tgt_lock_i(lock),
        .tgt_sel_i(sel), .tgt_adr_i(adr), .tgt_dat_i(wdat), .tgt_tgd_i(tgd),
        .tgt_ack_o(ack1), .tgt_err_o(err1), .tgt_rty_o(rty1), .tgt_stall_o(stall1),
        .tgt_dat_o(dato1), .tgt_tgd_o(tgdo1)
    );

    wb_tgt_ram #(.LATENCY(3), .MAX_OUTSTANDING(1)) dut_b (
        .clk_i(clk), .async_rst_i(async_rst_i), .sync_rst_i(sync_rst_i),
        .tgt_cyc_i(cyc2), .tgt_stb_i(stb2), .tgt_we_i(we), .tgt_lock_i(lock),
        .tgt_sel_i(sel), .tgt_adr_i(adr), .tgt_dat_i(wdat), .tgt_tgd_i(tgd),
        .tgt_ack_o(ack2), .tgt_err_o(err2), .tgt_rty_o(rty2), .tgt_stall_o(stall2),
        .tgt_dat_o(dato2), .tgt_tgd_o(tgdo2)
    );

    // Expected response: presented during the cycle following edge 'due'.
    typedef struct {
        int         due;
        bit         err;
        bit         rd;
        logic [15:0] dat;
        logic [0:0]  tgd;
    } exp_t;

    exp_t        q[$];
    int          edge_n = 0;
    int          active = 0;
    int          lat_m  = 2;
    int          max_m  = 2;
    logic [15:0] mmem [2][16];
    logic [0:0]  mtag [2][16];
    int          n_checks = 0;
    int          n_fail   = 0;
    bit          last_ack, last_err, last_stall;
    logic [15:0] last_rd_dat;
    logic [0:0]  last_rd_tgd;

    // One bus cycle: check outputs against the model, drive inputs, advance the model at the edge.
    task automatic step(input bit c, input bit s, input bit w, input logic [15:0] a,
                        input logic [15:0] d, input logic [1:0] sl, input logic [0:0] t,
                        input bit r);
        bit          pres, e_ack, e_err, e_stall, acc;
        logic [15:0] e_dat;
        logic [0:0]  e_tgd;
        logic        o_ack, o_err, o_rty, o_stall;
        logic [15:0] o_dat;
        logic [0:0]  o_tgd;
        exp_t        n;
        @(negedge clk);
        pres    = (q.size() > 0) && (q[0].due == edge_n);
        e_ack   = pres && !q[0].err;
        e_err   = pres && q[0].err;
        e_dat   = pres ? q[0].dat : 16'h0;
        e_tgd   = pres ? q[0].tgd : 1'b0;
        e_stall = (q.size() == max_m) && !pres;
        o_ack   = (active == 1) ? ack2   : ack1;
        o_err   = (active == 1) ? err2   : err1;
        o_rty   = (active == 1) ? rty2   : rty1;
        o_stall = (active == 1) ? stall2 : stall1;
        o_dat   = (active == 1) ? dato2  : dato1;
        o_tgd   = (active == 1) ? tgdo2  : tgdo1;
        n_checks += 6;
        if (o_ack !== e_ack) begin
            n_fail++; $display("FAIL ack dut%0d edge=%0d got=%b exp=%b", active, edge_n, o_ack, e_ack);
        end
        if (o_err !== e_err) begin
            n_fail++; $display("FAIL err dut%0d edge=%0d got=%b exp=%b", active, edge_n, o_err, e_err);
        end
        if (o_rty !== 1'b0) begin
            n_fail++; $display("FAIL rty dut%0d edge=%0d got=%b exp=0", active, edge_n, o_rty);
        end
        if (o_stall !== e_stall) begin
            n_fail++; $display("FAIL stall dut%0d edge=%0d got=%b exp=%b", active, edge_n, o_stall, e_stall);
        end
        if (o_dat !== e_dat) begin
            n_fail++; $display("FAIL dat dut%0d edge=%0d got=%h exp=%h", active, edge_n, o_dat, e_dat);
        end
        if (o_tgd !== e_tgd) begin
            n_fail++; $display("FAIL tgd dut%0d edge=%0d got=%b exp=%b", active, edge_n, o_tgd, e_tgd);
        end
        last_ack   = o_ack;
        last_err   = o_err;
        last_stall = o_stall;
        if (pres && q[0].rd && o_ack) begin
            last_rd_dat = o_dat;
            last_rd_tgd = o_tgd;
        end

        cyc1 = (active == 0) ? c : 1'b0;
        stb1 = (active == 0) ? s : 1'b0;
        cyc2 = (active == 1) ? c : 1'b0;
        stb2 = (active == 1) ? s : 1'b0;
        we = w; adr = a; wdat = d; sel = sl; tgd = t; sync_rst_i = r;
        acc = c && s && !e_stall && !r;

        @(posedge clk);
        edge_n++;
        if (!c || r) begin
            q.delete();
        end else begin
            while (q.size() > 0 && q[0].due < edge_n) void'(q.pop_front());
        end
        if (acc) begin
            n.due = edge_n + lat_m - 1;
            n.err = (a >= 16'd16);
            n.rd  = !w;
            n.dat = 16'h0;
            n.tgd = 1'b0;
            if (!n.err && !w) begin
                n.dat = mmem[active][a[3:0]];
                n.tgd = mtag[active][a[3:0]];
            end
            if (!n.err && w) begin
                if (sl[0]) mmem[active][a[3:0]][7:0]  = d[7:0];
                if (sl[1]) mmem[active][a[3:0]][15:8] = d[15:8];
                if (sl != 2'b00) mtag[active][a[3:0]] = t;
            end
            q.push_back(n);
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d, input logic [1:0] sl, input logic [0:0] t);
        step(1'b1, 1'b1, 1'b1, a, d, sl, t, 1'b0);
    endtask

    task automatic rd(input logic [15:0] a);
        step(1'b1, 1'b1, 1'b0, a, 16'h0, 2'b00, 1'b0, 1'b0);
    endtask

    task automatic hold(input int n);
        repeat (n) step(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00, 1'b0, 1'b0);
    endtask

    task automatic use_dut(input int which);
        idle(2);
        active = which;
        lat_m  = (which == 1) ? 3 : 2;
        max_m  = (which == 1) ? 1 : 2;
        q.delete();
    endtask

    task automatic test_reset();
        async_rst_i = 1'b1; sync_rst_i = 1'b0;
        cyc1 = 0; stb1 = 0; cyc2 = 0; stb2 = 0; we = 0; lock = 0;
        sel = 0; adr = 0; wdat = 0; tgd = 0;
        repeat (2) @(posedge clk);
        #1;
        n_checks += 2;
        if ({ack1, err1, rty1, stall1, dato1, tgdo1} !== 20'h0) begin
            n_fail++; $display("FAIL reset_a got=%h exp=0", {ack1, err1, rty1, stall1, dato1, tgdo1});
        end
        if ({ack2, err2, rty2, stall2, dato2, tgdo2} !== 20'h0) begin
            n_fail++; $display("FAIL reset_b got=%h exp=0", {ack2, err2, rty2, stall2, dato2, tgdo2});
        end
        @(negedge clk);
        async_rst_i = 1'b0;
    endtask

    task automatic test_init_mem();
        for (int dv = 0; dv < 2; dv++) begin
            use_dut(dv);
            for (int i = 0; i < 16; i++) begin
                wr(16'(i), 16'($urandom), 2'b11, 1'($urandom));
                hold(3);
            end
        end
        use_dut(0);
    endtask

    task automatic test_write_read();
        last_rd_dat = 16'h0; last_rd_tgd = 1'b0;
        wr(16'd3, 16'hBEEF, 2'b11, 1'b1);
        rd(16'd3);
        hold(3);
        n_checks += 2;
        if (last_rd_dat !== 16'hBEEF) begin
            n_fail++; $display("FAIL wr_rd_dat got=%h exp=beef", last_rd_dat);
        end
        if (last_rd_tgd !== 1'b1) begin
            n_fail++; $display("FAIL wr_rd_tgd got=%b exp=1", last_rd_tgd);
        end
    endtask

    task automatic test_byte_lane();
        last_rd_dat = 16'h0;
        wr(16'd3, 16'h1234, 2'b01, 1'b0);
        rd(16'd3);
        hold(3);
        n_checks++;
        if (last_rd_dat !== 16'hBE34) begin
            n_fail++; $display("FAIL byte_lane got=%h exp=be34", last_rd_dat);
        end
    endtask

    task automatic test_back_to_back();
        int acks = 0, stalls = 0, run = 0, best = 0;
        for (int i = 0; i < 7; i++) begin
            if (i < 4) rd(16'(i)); else hold(1);
            if (last_ack) begin acks++; run++; end else run = 0;
            if (run > best) best = run;
            if (last_stall) stalls++;
        end
        hold(1);
        if (last_ack) acks++;
        n_checks += 3;
        if (acks != 4)   begin n_fail++; $display("FAIL b2b_acks got=%0d exp=4", acks); end
        if (best != 4)   begin n_fail++; $display("FAIL b2b_run got=%0d exp=4", best); end
        if (stalls != 0) begin n_fail++; $display("FAIL b2b_stall got=%0d exp=0", stalls); end
    endtask

    task automatic test_stall_limit();
        int acks = 0, stalls = 0;
        use_dut(1);
        for (int i = 0; i < 12; i++) begin
            rd(16'($urandom_range(0, 15)));
            if (last_stall) stalls++;
            if (last_ack) acks++;
        end
        for (int i = 0; i < 3; i++) begin
            hold(1);
            if (last_ack) acks++;
        end
        n_checks += 2;
        if (stalls != 8) begin n_fail++; $display("FAIL lim_stall got=%0d exp=8", stalls); end
        if (acks != 4)   begin n_fail++; $display("FAIL lim_acks got=%0d exp=4", acks); end
        use_dut(0);
    endtask

    task automatic test_out_of_range();
        int errs = 0, acks = 0;
        last_rd_dat = 16'h0;
        rd(16'h0010);
        for (int i = 0; i < 3; i++) begin
            hold(1);
            if (last_err) errs++;
            if (last_ack) acks++;
        end
        wr(16'h0013, 16'hDEAD, 2'b11, 1'b1);
        for (int i = 0; i < 3; i++) begin
            hold(1);
            if (last_err) errs++;
        end
        rd(16'd3);
        hold(3);
        n_checks += 3;
        if (errs != 2)   begin n_fail++; $display("FAIL oor_errs got=%0d exp=2", errs); end
        if (acks != 0)   begin n_fail++; $display("FAIL oor_acks got=%0d exp=0", acks); end
        if (last_rd_dat !== 16'hBE34) begin
            n_fail++; $display("FAIL oor_ram got=%h exp=be34", last_rd_dat);
        end
    endtask

    task automatic test_abort();
        int late = 0, stalls = 0;
        rd(16'd1);
        rd(16'd2);
        idle(1);
        for (int i = 0; i < 3; i++) begin
            idle(1);
            if (last_ack || last_err) late++;
            if (last_stall) stalls++;
        end
        n_checks += 2;
        if (late != 0)   begin n_fail++; $display("FAIL abort_rsp got=%0d exp=0", late); end
        if (stalls != 0) begin n_fail++; $display("FAIL abort_stall got=%0d exp=0", stalls); end
        rd(16'd4); rd(16'd5); hold(3);
    endtask

    task automatic test_sync_reset();
        int late = 0;
        rd(16'd4);
        rd(16'd5);
        step(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            hold(1);
            if (last_ack || last_err) late++;
        end
        n_checks++;
        if (late != 0) begin n_fail++; $display("FAIL srst_rsp got=%0d exp=0", late); end
    endtask

    task automatic test_async_reset();
        wr(16'd5, 16'h5A5A, 2'b11, 1'b1);
        wr(16'd6, 16'hC3C3, 2'b11, 1'b0);
        rd(16'd5);
        rd(16'd6);
        #2 async_rst_i = 1'b1;
        #1;
        n_checks += 2;
        if ({ack1, err1, stall1} !== 3'b000) begin
            n_fail++; $display("FAIL arst_ctl got=%b exp=000", {ack1, err1, stall1});
        end
        if ({dato1, tgdo1} !== 17'h0) begin
            n_fail++; $display("FAIL arst_dat got=%h exp=0", {dato1, tgdo1});
        end
        q.delete();
        #1 async_rst_i = 1'b0;
        idle(2);
        last_rd_dat = 16'h0;
        rd(16'd5);
        hold(3);
        n_checks++;
        if (last_rd_dat !== 16'h5A5A) begin
            n_fail++; $display("FAIL arst_ram got=%h exp=5a5a", last_rd_dat);
        end
    endtask

    task automatic test_random(input int which, input int n);
        bit c, s, w, r;
        logic [15:0] a;
        use_dut(which);
        for (int i = 0; i < n; i++) begin
            c = ($urandom_range(0, 15) != 0);
            s = ($urandom_range(0, 3) != 0);
            w = 1'($urandom_range(0, 1));
            r = ($urandom_range(0, 63) == 0);
            a = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(16, 65535))
                                            : 16'($urandom_range(0, 15));
            step(c, s, w, a, 16'($urandom), 2'($urandom), 1'($urandom), r);
        end
        hold(5);
        use_dut(0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_init_mem();
        test_write_read();
        test_byte_lane();
        test_back_to_back();
        test_stall_limit();
        test_out_of_range();
        test_abort();
        test_sync_reset();
        test_async_reset();
        test_random(0, 400);
        test_random(1, 300);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
